// File: rtl/bayer_pkg.sv
// bayer_pkg
// Shared definitions for the Bayer row-buffer sequencer:
//   - state_t    : sequencer state encoding (IDLE=0, PRIME=1, ACTIVE=2, WAIT_FEND=3)
//   - DEF_*      : default frame geometry and counter widths
package bayer_pkg;

  localparam int DEF_ROW_WIDTH = 1280;
  localparam int DEF_ROW_COUNT = 960;
  localparam int DEF_COL_W     = 11;
  localparam int DEF_ROW_W     = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRIME     = 2'd1,
    ACTIVE    = 2'd2,
    WAIT_FEND = 2'd3
  } state_t;

endpackage

// File: rtl/bayer_pos_counter.sv
// bayer_pos_counter
// Column/row position counter for the Bayer sequencer.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   clear      : return to column 0, row 0 (frame start)
//   inc        : one accepted pixel this cycle
//   advance    : force a move to column 0 of the next row (short-line realign)
//   col, row   : current position
//   col_last   : col is the last column of a row
//   row_last   : row is the last row of a frame
//   line_wrap  : this cycle ends a row (normal wrap or forced advance)
module bayer_pos_counter
  import bayer_pkg::*;
#(
  parameter int ROW_WIDTH = DEF_ROW_WIDTH,
  parameter int ROW_COUNT = DEF_ROW_COUNT,
  parameter int COL_W     = DEF_COL_W,
  parameter int ROW_W     = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_last,
  output logic             row_last,
  output logic             line_wrap
);

  assign col_last  = (col == COL_W'(ROW_WIDTH - 1));
  assign row_last  = (row == ROW_W'(ROW_COUNT - 1));
  assign line_wrap = advance | (inc & col_last);

  // Row wraps back to 0 after the last row so the counter can never leave
  // the frame; the sequencer stops feeding it once the frame is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (line_wrap) begin
      col <= '0;
      row <= row_last ? '0 : row + ROW_W'(1);
    end else if (inc) begin
      col <= col + COL_W'(1);
    end
  end

endmodule

// File: rtl/bayer_window_ctrl.sv
// bayer_window_ctrl
// Frame/line sequencer for the Bayer row-buffer stage. Follows the D5M
// frame/line/pixel strobes, drives the row-buffer write enable and flags the
// cycles where the buffer taps hold a complete 2x2 Bayer block.
// Ports:
//   iCLK, iRST          : pixel clock, async active-low reset
//   iFVAL, iLVAL, iDVAL : frame / line / pixel valid from the CCD capture
//   oBUF_EN             : row-buffer write enable (combinational)
//   oBLK_VAL            : full 2x2 block at the taps this cycle
//   oBLK_X, oBLK_Y      : block coordinates (col>>1, row>>1)
//   oFRAME_START/DONE   : one-cycle frame boundary pulses
//   oLINE_ERR           : one-cycle pulse on short line or truncated frame
// Optional feature (macro BAYER_CTRL_STATS_EN):
//   oFRAME_CNT          : completed frames, wrapping
//   oERR_CNT            : line errors, saturating at 255
module bayer_window_ctrl
  import bayer_pkg::*;
#(
  parameter int ROW_WIDTH = DEF_ROW_WIDTH,
  parameter int ROW_COUNT = DEF_ROW_COUNT,
  parameter int COL_W     = DEF_COL_W,
  parameter int ROW_W     = DEF_ROW_W
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic             iDVAL,
  output logic             oBUF_EN,
  output logic             oBLK_VAL,
  output logic [COL_W-2:0] oBLK_X,
  output logic [ROW_W-2:0] oBLK_Y,
  output logic             oFRAME_START,
  output logic             oFRAME_DONE,
  output logic             oLINE_ERR
`ifdef BAYER_CTRL_STATS_EN
  ,
  output logic [15:0]      oFRAME_CNT,
  output logic [7:0]       oERR_CNT
`endif
);

  state_t state, state_next;

  logic fval_d, lval_d;
  logic fval_rise, fval_fall, lval_fall;
  logic in_frame, accept, short_line, clear;
  logic start_next, done_next, err_next;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last, row_last, line_wrap;

  assign fval_rise = iFVAL & ~fval_d;
  assign fval_fall = ~iFVAL & fval_d;
  assign lval_fall = ~iLVAL & lval_d;

  assign in_frame = (state == PRIME) || (state == ACTIVE);
  assign accept   = iDVAL & in_frame;
  assign oBUF_EN  = accept;

  // A line ending before the last column is short; a wrapping pixel that
  // coincides with the falling edge is a normal line end.
  assign short_line = lval_fall & in_frame & (col != '0) & ~(accept & col_last);

  bayer_pos_counter #(
    .ROW_WIDTH (ROW_WIDTH),
    .ROW_COUNT (ROW_COUNT),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_pos (
    .clk       (iCLK),
    .rst_n     (iRST),
    .clear     (clear),
    .inc       (accept),
    .advance   (short_line),
    .col       (col),
    .row       (row),
    .col_last  (col_last),
    .row_last  (row_last),
    .line_wrap (line_wrap)
  );

  // Edge-detect history starts high so a frame already running when reset
  // is released produces no rising edge and is skipped.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fval_d <= 1'b1;
      lval_d <= 1'b1;
    end else begin
      fval_d <= iFVAL;
      lval_d <= iLVAL;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= IDLE;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oLINE_ERR    <= 1'b0;
    end else begin
      state        <= state_next;
      oFRAME_START <= start_next;
      oFRAME_DONE  <= done_next;
      oLINE_ERR    <= err_next;
    end
  end

  // A frame falling edge outranks any row transition in the same cycle; a
  // falling edge before the frame completed also counts as a line error.
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    clear      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fval_rise) begin
          state_next = PRIME;
          start_next = 1'b1;
          clear      = 1'b1;
        end
      end
      PRIME, ACTIVE: begin
        err_next = short_line;
        if (line_wrap) begin
          if (state == PRIME)
            state_next = ACTIVE;
          else if (row_last)
            state_next = WAIT_FEND;
        end
        if (fval_fall) begin
          state_next = IDLE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end
      WAIT_FEND: begin
        if (fval_fall) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The taps hold a full block one cycle after an odd-row, odd-column pixel
  // is written; coordinates are held between blocks.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oBLK_VAL <= 1'b0;
      oBLK_X   <= '0;
      oBLK_Y   <= '0;
    end else begin
      oBLK_VAL <= accept & col[0] & row[0];
      if (accept & col[0] & row[0]) begin
        oBLK_X <= col[COL_W-1:1];
        oBLK_Y <= row[ROW_W-1:1];
      end
    end
  end

`ifdef BAYER_CTRL_STATS_EN
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFRAME_CNT <= '0;
      oERR_CNT   <= '0;
    end else begin
      if (oFRAME_DONE)
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      if (oLINE_ERR && (oERR_CNT != 8'hFF))
        oERR_CNT <= oERR_CNT + 8'd1;
    end
  end
`endif

endmodule
